// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_mem_pkg
// Brief  : dmem access-size encodings, LSU state type, lane extract/merge.
// Rev    : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Pull the addressed little-endian lane out of a word and extend it.
    function automatic logic [31:0] lsu_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    res = {{24{lane_b[7] & ~uns}}, lane_b};
            SZ_H:    res = {{16{lane_h[15] & ~uns}}, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of word with the low bits of wdata.
    function automatic logic [31:0] lsu_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        logic [31:0] res;
        res = word;
        case (size)
            SZ_B: begin
                case (off)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    default: res[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (off[1]) res[31:16] = wdata[15:0];
                else        res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : combinational load extract/extend and store lane-merge datapath.
// Rev    : 1.0
// ============================================================================
module lsu_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data  = lsu_extract(rd_word, off, size, uns);
        merge_data = lsu_merge(rd_word, wdata, off, size);
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module : dmem_lsu
// Brief  : byte/half/word load-store initiator for a word-only dmem,
//          with read-modify-write for sub-word stores.
// Rev    : 1.0
// ============================================================================
module dmem_lsu
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_wd;

    logic        w_accept;
    logic        w_req_err;
    logic        w_word_store;
    logic [31:0] w_word_idx;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept     = req_valid & (r_state == ST_IDLE);
    assign w_word_idx   = {2'b00, req_addr[31:2]};
    assign w_word_store = req_we & (req_size == SZ_W);

    // Any of these short-circuits straight to RESP with no dmem traffic.
    assign w_req_err = (req_size == 2'b11)
                     | ((req_size == SZ_H) & req_addr[0])
                     | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                     | (w_word_idx >= MEM_WORDS_U);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)         w_state_nxt = ST_RESP;
                    else if (w_word_store) w_state_nxt = ST_WRITE;
                    else                   w_state_nxt = ST_READ;
                end
            end
            ST_READ:  w_state_nxt = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= SZ_B;
            r_uns    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_mem_wd <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_err   <= w_req_err;
                        r_rdata <= '0;
                        if (w_word_store && !w_req_err) r_mem_wd <= req_wdata;
                    end
                end
                // dmem read is combinational on mem_a, so the word is valid here.
                ST_READ: begin
                    if (r_we) r_mem_wd <= w_merge_data;
                    else      r_rdata  <= w_load_data;
                end
                default: ;
            endcase
        end
    end

    lsu_align u_align (
        .rd_word    (mem_rd),
        .wdata      (r_wdata),
        .off        (r_addr[1:0]),
        .size       (r_size),
        .uns        (r_uns),
        .load_data  (w_load_data),
        .merge_data (w_merge_data)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_we     = (r_state == ST_WRITE);
    assign mem_a      = {r_addr[31:2], 2'b00};
    assign mem_wd     = r_mem_wd;

endmodule
`default_nettype wire
